// File: rtl/input_conditioner.sv
// Multi-channel input conditioner: per-channel synchronizer chain, debounce
// counter, registered stable level and one-cycle rise/fall pulses.
module input_conditioner #(
    parameter int unsigned WIDTH           = 4,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] sync_out,
    output logic [WIDTH-1:0] stable_out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             any_stable
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];

    // Synchronizer chain: stage 0 samples the raw inputs, last stage is sync_out.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
        end else begin
            sync_q[0] <= in;
            for (int unsigned s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    assign sync_out = sync_q[SYNC_STAGES-1];

    for (genvar i = 0; i < int'(WIDTH); i++) begin : g_chan
        logic [CNT_W-1:0] cnt;
        logic             stable_q;
        logic             rise_q;
        logic             fall_q;

        // Debounce: count consecutive mismatch cycles, accept on the last one;
        // any return to the stable level restarts the count from zero.
        always_ff @(posedge clk) begin
            if (reset) begin
                cnt      <= '0;
                stable_q <= 1'b0;
                rise_q   <= 1'b0;
                fall_q   <= 1'b0;
            end else begin
                rise_q <= 1'b0;
                fall_q <= 1'b0;
                if (sync_out[i] == stable_q) begin
                    cnt <= '0;
                end else if (cnt == CNT_LAST) begin
                    cnt      <= '0;
                    stable_q <= sync_out[i];
                    rise_q   <= sync_out[i];
                    fall_q   <= ~sync_out[i];
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end

        assign stable_out[i] = stable_q;
        assign rise[i]       = rise_q;
        assign fall[i]       = fall_q;
    end

    assign any_stable = |stable_out;

endmodule

// File: tb/tb_input_conditioner.sv
// Self-checking bench for input_conditioner (WIDTH=4, SYNC_STAGES=2,
// DEBOUNCE_CYCLES=4). Each step drives inputs, queues the expected outputs
// for the following edge, then pops and compares them after that edge.
module tb_input_conditioner;

    typedef struct packed {
        logic [3:0] in;
        logic [3:0] sync;
        logic [3:0] stable;
        logic [3:0] rise;
        logic [3:0] fall;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] in;
    logic [3:0] sync_out;
    logic [3:0] stable_out;
    logic [3:0] rise;
    logic [3:0] fall;
    logic       any_stable;

    int errors = 0;
    int checks = 0;

    vec_t exp_q[$];
    vec_t tbl[26];

    input_conditioner #(
        .WIDTH          (4),
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in        (in),
        .sync_out  (sync_out),
        .stable_out(stable_out),
        .rise      (rise),
        .fall      (fall),
        .any_stable(any_stable)
    );

    always #5 clk = ~clk;

    task automatic cmp4(input string name, input int step_no, input logic [3:0] act, input logic [3:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s step %0d: got %b, expected %b", name, step_no, act, req);
        end
    endtask

    // Drive one cycle of stimulus, queue its expectation, compare after the edge.
    task automatic step(input string name, input int step_no, input logic rst_v, input vec_t v);
        vec_t e;
        exp_q.push_back(v);
        reset = rst_v;
        in    = v.in;
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        cmp4({name, ".sync_out"},   step_no, sync_out,   e.sync);
        cmp4({name, ".stable_out"}, step_no, stable_out, e.stable);
        cmp4({name, ".rise"},       step_no, rise,       e.rise);
        cmp4({name, ".fall"},       step_no, fall,       e.fall);
        checks++;
        if (any_stable !== (|e.stable)) begin
            errors++;
            $display("FAIL %s.any_stable step %0d: got %b, expected %b", name, step_no, any_stable, |e.stable);
        end
    endtask

    task automatic do_reset(input string name);
        for (int k = 1; k <= 2; k++) begin
            step(name, k, 1'b1, '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000});
        end
    endtask

    initial begin
        reset = 1'b1;
        in    = 4'b0000;

        // Press ch1 (rise at 6th step), glitch ch2 for 3 cycles, bounce ch0.
        //          in       sync     stable   rise     fall
        tbl[0]  = '{4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        tbl[1]  = '{4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0000};
        tbl[2]  = '{4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0000};
        tbl[3]  = '{4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0000};
        tbl[4]  = '{4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0000};
        tbl[5]  = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0000};
        tbl[6]  = '{4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0000};
        tbl[7]  = '{4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0000};
        tbl[8]  = '{4'b0110, 4'b0010, 4'b0010, 4'b0000, 4'b0000};
        tbl[9]  = '{4'b0110, 4'b0110, 4'b0010, 4'b0000, 4'b0000};
        tbl[10] = '{4'b0110, 4'b0110, 4'b0010, 4'b0000, 4'b0000};
        tbl[11] = '{4'b0010, 4'b0110, 4'b0010, 4'b0000, 4'b0000};
        tbl[12] = '{4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0000};
        tbl[13] = '{4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0000};
        tbl[14] = '{4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0000};
        tbl[15] = '{4'b0011, 4'b0010, 4'b0010, 4'b0000, 4'b0000};
        tbl[16] = '{4'b0010, 4'b0011, 4'b0010, 4'b0000, 4'b0000};
        tbl[17] = '{4'b0011, 4'b0010, 4'b0010, 4'b0000, 4'b0000};
        tbl[18] = '{4'b0010, 4'b0011, 4'b0010, 4'b0000, 4'b0000};
        tbl[19] = '{4'b0011, 4'b0010, 4'b0010, 4'b0000, 4'b0000};
        tbl[20] = '{4'b0011, 4'b0011, 4'b0010, 4'b0000, 4'b0000};
        tbl[21] = '{4'b0011, 4'b0011, 4'b0010, 4'b0000, 4'b0000};
        tbl[22] = '{4'b0011, 4'b0011, 4'b0010, 4'b0000, 4'b0000};
        tbl[23] = '{4'b0011, 4'b0011, 4'b0010, 4'b0000, 4'b0000};
        tbl[24] = '{4'b0011, 4'b0011, 4'b0011, 4'b0001, 4'b0000};
        tbl[25] = '{4'b0011, 4'b0011, 4'b0011, 4'b0000, 4'b0000};

        // Reset release: everything stays quiet for 20 cycles.
        do_reset("rst");
        for (int k = 1; k <= 20; k++) begin
            step("idle", k, 1'b0, '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000});
        end

        for (int k = 0; k < 26; k++) begin
            step("tbl", k, 1'b0, tbl[k]);
        end

        // Raise ch2/ch3 to reach stable_out=1111.
        for (int k = 1; k <= 8; k++) begin
            step("all_hi", k, 1'b0, '{4'b1111,
                                       (k == 1) ? 4'b0011 : 4'b1111,
                                       (k < 6)  ? 4'b0011 : 4'b1111,
                                       (k == 6) ? 4'b1100 : 4'b0000,
                                       4'b0000});
        end

        // Simultaneous release of all channels.
        for (int k = 1; k <= 8; k++) begin
            step("release", k, 1'b0, '{4'b0000,
                                        (k == 1) ? 4'b1111 : 4'b0000,
                                        (k < 6)  ? 4'b1111 : 4'b0000,
                                        4'b0000,
                                        (k == 6) ? 4'b1111 : 4'b0000});
        end

        // Reset mid-count: ch3 reaches count 2, reset for one cycle, in held high.
        do_reset("rst2");
        for (int k = 1; k <= 4; k++) begin
            step("pre_rst", k, 1'b0, '{4'b1000,
                                        (k == 1) ? 4'b0000 : 4'b1000,
                                        4'b0000, 4'b0000, 4'b0000});
        end
        step("mid_rst", 1, 1'b1, '{4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0000});
        for (int k = 1; k <= 8; k++) begin
            step("post_rst", k, 1'b0, '{4'b1000,
                                         (k == 1) ? 4'b0000 : 4'b1000,
                                         (k < 6)  ? 4'b0000 : 4'b1000,
                                         (k == 6) ? 4'b1000 : 4'b0000,
                                         4'b0000});
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
